// File: rtl/rv_seq_pkg.sv
// Shared encodings for the RV32I multi-cycle phase sequencer and its decoder.
package rv_seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_HALT    = 3'd5
    } seq_state_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_sel_e;

    typedef enum logic [1:0] {
        HALT_NONE    = 2'b00,
        HALT_ILLEGAL = 2'b01,
        HALT_IMEM_TO = 2'b10,
        HALT_DMEM_TO = 2'b11
    } halt_cause_e;

    // Branch class as produced by the decoder; 2'b11 is unused.
    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_COND = 2'b01,
        BR_JUMP = 2'b10
    } br_class_e;

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic [1:0] branch;
    } ctrl_t;

    function automatic pc_sel_e pc_sel_of(input logic [1:0] branch, input logic taken);
        pc_sel_e sel;
        sel = PC_PLUS4;
        if (branch == BR_JUMP) begin
            sel = PC_JUMP;
        end else if (branch == BR_COND && taken) begin
            sel = PC_BRANCH;
        end
        return sel;
    endfunction

endpackage

// File: rtl/rv_seq_wait_timer.sv
// Memory-wait watchdog: counts stalled request cycles and flags expiry on the
// TIMEOUT-th one. TIMEOUT = 0 disables expiry.
module rv_seq_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_wait,
    output logic o_expire
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_wait && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Expiry is raised during the stalled cycle that would make the count reach TIMEOUT.
    assign o_expire = (TIMEOUT != 0) && i_wait && (r_cnt == LAST);

endmodule

// File: rtl/rv_mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB phase sequencer for the RV32I core,
// with retire counting and halt on illegal opcode or memory timeout.
module rv_mc_sequencer
    import rv_seq_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic             i_regwrite,
    input  logic             i_memread,
    input  logic             i_memwrite,
    input  logic [1:0]       i_branch,
    input  logic             i_branch_taken,
    input  logic             i_illegal,
    input  logic             i_imem_ready,
    input  logic             i_dmem_ready,
    output logic             o_imem_req,
    output logic             o_ir_we,
    output logic             o_alu_en,
    output logic             o_dmem_req,
    output logic             o_dmem_we,
    output logic             o_rf_we,
    output logic             o_pc_we,
    output logic [1:0]       o_pc_sel,
    output logic [2:0]       o_state,
    output logic             o_halted,
    output logic [1:0]       o_halt_cause,
    output logic [CNT_W-1:0] o_instret
);

    seq_state_e       r_state;
    seq_state_e       w_next;
    halt_cause_e      r_cause;
    halt_cause_e      w_cause;
    ctrl_t            r_ctrl;
    logic             r_taken;
    logic [CNT_W-1:0] r_instret;

    logic w_imem_req, w_dmem_req, w_imem_xfer, w_dmem_xfer;
    logic w_wait, w_clr, w_expire, w_taken;
    logic w_ir_we, w_alu_en, w_dmem_we, w_rf_we, w_retire;

    // Fetch request is dropped combinationally while reset is asserted.
    assign w_imem_req  = (r_state == ST_FETCH) && i_run && i_rst_n;
    assign w_dmem_req  = (r_state == ST_MEM);
    assign w_imem_xfer = w_imem_req && i_imem_ready;
    assign w_dmem_xfer = w_dmem_req && i_dmem_ready;
    assign w_wait      = (w_imem_req && !i_imem_ready) || (w_dmem_req && !i_dmem_ready);
    assign w_clr       = !((r_state == ST_FETCH) || (r_state == ST_MEM)) || w_imem_xfer || w_dmem_xfer;

    rv_seq_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (w_clr),
        .i_wait   (w_wait),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_FETCH;
            r_cause   <= HALT_NONE;
            r_ctrl    <= '0;
            r_taken   <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause;
            if (r_state == ST_DECODE) begin
                r_ctrl <= '{regwrite: i_regwrite, memread: i_memread,
                            memwrite: i_memwrite, branch: i_branch};
            end
            if (r_state == ST_EXECUTE) begin
                r_taken <= i_branch_taken;
            end
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cause   = r_cause;
        w_ir_we   = 1'b0;
        w_alu_en  = 1'b0;
        w_dmem_we = 1'b0;
        w_rf_we   = 1'b0;
        w_retire  = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (w_imem_xfer) begin
                    w_ir_we = 1'b1;
                    w_next  = ST_DECODE;
                end else if (w_expire) begin
                    w_next  = ST_HALT;
                    w_cause = HALT_IMEM_TO;
                end
            end
            ST_DECODE: begin
                if (i_illegal) begin
                    w_next  = ST_HALT;
                    w_cause = HALT_ILLEGAL;
                end else begin
                    w_next = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                w_alu_en = 1'b1;
                if (r_ctrl.memread || r_ctrl.memwrite) begin
                    w_next = ST_MEM;
                end else if (r_ctrl.regwrite) begin
                    w_next = ST_WB;
                end else begin
                    w_retire = 1'b1;
                    w_next   = ST_FETCH;
                end
            end
            ST_MEM: begin
                w_dmem_we = r_ctrl.memwrite;
                if (w_dmem_xfer) begin
                    if (r_ctrl.regwrite) begin
                        w_next = ST_WB;
                    end else begin
                        w_retire = 1'b1;
                        w_next   = ST_FETCH;
                    end
                end else if (w_expire) begin
                    w_next  = ST_HALT;
                    w_cause = HALT_DMEM_TO;
                end
            end
            ST_WB: begin
                w_rf_we  = 1'b1;
                w_retire = 1'b1;
                w_next   = ST_FETCH;
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_FETCH;
            end
        endcase
    end

    // Branch outcome is consumed live when retiring in EXECUTE, latched afterwards.
    assign w_taken = (r_state == ST_EXECUTE) ? i_branch_taken : r_taken;

    assign o_imem_req   = w_imem_req;
    assign o_ir_we      = w_ir_we;
    assign o_alu_en     = w_alu_en;
    assign o_dmem_req   = w_dmem_req;
    assign o_dmem_we    = w_dmem_we;
    assign o_rf_we      = w_rf_we;
    assign o_pc_we      = w_retire;
    assign o_pc_sel     = pc_sel_of(r_ctrl.branch, w_taken);
    assign o_state      = r_state;
    assign o_halted     = (r_state == ST_HALT);
    assign o_halt_cause = r_cause;
    assign o_instret    = r_instret;

endmodule

// File: tb/tb_rv_mc_sequencer.sv
// Cycle-accurate check of rv_mc_sequencer against an instruction-level model
// that expands each instruction class into its expected phase sequence.
module tb_rv_mc_sequencer;

    localparam int CNT_W = 4;
    localparam int TMO   = 4;
    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JAL = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_run, i_regwrite, i_memread, i_memwrite;
    logic [1:0]       i_branch;
    logic             i_branch_taken, i_illegal, i_imem_ready, i_dmem_ready;
    logic             o_imem_req, o_ir_we, o_alu_en, o_dmem_req, o_dmem_we, o_rf_we, o_pc_we;
    logic [1:0]       o_pc_sel;
    logic [2:0]       o_state;
    logic             o_halted;
    logic [1:0]       o_halt_cause;
    logic [CNT_W-1:0] o_instret;

    int checks = 0;
    int errors = 0;
    int exp_ret;
    int m_cause;

    always #5 clk = ~clk;

    rv_mc_sequencer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TMO)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_run          (i_run),
        .i_regwrite     (i_regwrite),
        .i_memread      (i_memread),
        .i_memwrite     (i_memwrite),
        .i_branch       (i_branch),
        .i_branch_taken (i_branch_taken),
        .i_illegal      (i_illegal),
        .i_imem_ready   (i_imem_ready),
        .i_dmem_ready   (i_dmem_ready),
        .o_imem_req     (o_imem_req),
        .o_ir_we        (o_ir_we),
        .o_alu_en       (o_alu_en),
        .o_dmem_req     (o_dmem_req),
        .o_dmem_we      (o_dmem_we),
        .o_rf_we        (o_rf_we),
        .o_pc_we        (o_pc_we),
        .o_pc_sel       (o_pc_sel),
        .o_state        (o_state),
        .o_halted       (o_halted),
        .o_halt_cause   (o_halt_cause),
        .o_instret      (o_instret)
    );

    function automatic int r1();
        return int'($urandom_range(1, 0));
    endfunction

    function automatic int r2();
        return int'($urandom_range(3, 0));
    endfunction

    // Expected output vector; pc_sel only matters when pc_we is set.
    function automatic logic [31:0] ev(input int st, input int ireq, input int irwe, input int alu,
                                       input int dreq, input int dwe, input int rfwe, input int pcwe,
                                       input int sel);
        logic [14:0] v;
        v = {3'(st), 1'(ireq), 1'(irwe), 1'(alu), 1'(dreq), 1'(dwe), 1'(rfwe), 1'(pcwe),
             (pcwe != 0) ? 2'(sel) : 2'd0, 1'(st == 5), 2'(m_cause)};
        return 32'(v);
    endfunction

    function automatic logic [31:0] obs_vec();
        logic [14:0] v;
        v = {o_state, o_imem_req, o_ir_we, o_alu_en, o_dmem_req, o_dmem_we, o_rf_we, o_pc_we,
             o_pc_we ? o_pc_sel : 2'd0, o_halted, o_halt_cause};
        return 32'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int run, input int irdy, input int drdy, input int rw, input int mr,
                        input int mw, input int br, input int tk, input int ill,
                        input logic [31:0] exp_v, input string tag);
        @(negedge clk);
        i_run          = 1'(run);
        i_imem_ready   = 1'(irdy);
        i_dmem_ready   = 1'(drdy);
        i_regwrite     = 1'(rw);
        i_memread      = 1'(mr);
        i_memwrite     = 1'(mw);
        i_branch       = 2'(br);
        i_branch_taken = 1'(tk);
        i_illegal      = 1'(ill);
        #1;
        chk(tag, obs_vec(), exp_v);
        chk({tag, "_instret"}, 32'(o_instret), 32'(exp_ret));
        if (exp_v[5]) exp_ret = (exp_ret + 1) % (1 << CNT_W);
    endtask

    // Decoder/ALU inputs are junk outside the phase that samples them.
    task automatic step_g(input int run, input int irdy, input int drdy,
                          input logic [31:0] exp_v, input string tag);
        step(run, irdy, drdy, r1(), r1(), r1(), r2(), r1(), r1(), exp_v, tag);
    endtask

    // iw/dw: wait cycles before ready; >= TMO never ready (timeout); dw < 0 stops after 2 MEM waits.
    task automatic do_instr(input int kind, input int iw, input int dw, input int tk);
        int rw, mr, mw, br, sel, ret_ex, nw;
        rw  = (kind == K_ALU || kind == K_LOAD || kind == K_JAL) ? 1 : 0;
        mr  = (kind == K_LOAD) ? 1 : 0;
        mw  = (kind == K_STORE) ? 1 : 0;
        br  = (kind == K_BR) ? 1 : (kind == K_JAL) ? 2 : 0;
        sel = (br == 2) ? 2 : (br == 1 && tk != 0) ? 1 : 0;
        for (int i = 0; i < iw && i < TMO; i++)
            step_g(1, 0, r1(), ev(0, 1, 0, 0, 0, 0, 0, 0, 0), "fetch_wait");
        if (iw >= TMO) begin
            m_cause = 2;
            return;
        end
        step_g(1, 1, r1(), ev(0, 1, 1, 0, 0, 0, 0, 0, 0), "fetch");
        step(r1(), r1(), r1(), rw, mr, mw, br, r1(), 0, ev(1, 0, 0, 0, 0, 0, 0, 0, 0), "decode");
        ret_ex = (rw == 0 && mr == 0 && mw == 0) ? 1 : 0;
        step(r1(), r1(), r1(), r1(), r1(), r1(), r2(), tk, r1(),
             ev(2, 0, 0, 1, 0, 0, 0, ret_ex, sel), "execute");
        if (mr != 0 || mw != 0) begin
            nw = (dw < 0) ? 2 : (dw >= TMO) ? TMO : dw;
            for (int i = 0; i < nw; i++)
                step_g(r1(), r1(), 0, ev(3, 0, 0, 0, 1, mw, 0, 0, 0), "mem_wait");
            if (dw < 0) return;
            if (dw >= TMO) begin
                m_cause = 3;
                return;
            end
            step_g(r1(), r1(), 1, ev(3, 0, 0, 0, 1, mw, 0, (rw == 0) ? 1 : 0, 0), "mem");
        end
        if (rw != 0) step_g(r1(), r1(), r1(), ev(4, 0, 0, 0, 0, 0, 1, 1, sel), "wb");
    endtask

    task automatic halt_steps(input int n);
        for (int i = 0; i < n; i++)
            step_g(1, 1, r1(), ev(5, 0, 0, 0, 0, 0, 0, 0, 0), "halt");
    endtask

    // mid != 0: assert reset asynchronously inside the current cycle with i_run still high.
    task automatic do_reset(input int mid, input string tag);
        if (mid != 0) #2;
        else @(negedge clk);
        rst_n = 1'b0;
        i_run = 1'b1;
        #1;
        exp_ret = 0;
        m_cause = 0;
        chk(tag, obs_vec(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk({tag, "_instret"}, 32'(o_instret), 32'd0);
        i_run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        {i_run, i_regwrite, i_memread, i_memwrite, i_branch_taken, i_illegal} = '0;
        {i_imem_ready, i_dmem_ready} = '0;
        i_branch = 2'd0;
        exp_ret = 0;
        m_cause = 0;
        #1;
        chk("reset_state", obs_vec(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("reset_instret", 32'(o_instret), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_instr(K_ALU, 0, 0, 0);
        do_instr(K_LOAD, 0, 3, 0);
        do_instr(K_BR, 0, 0, 1);
        do_instr(K_BR, 0, 0, 0);
        do_instr(K_JAL, 0, 0, r1());
        do_instr(K_STORE, 0, 0, 0);
        do_instr(K_STORE, 2, 3, 1);
        do_instr(K_ALU, 3, 0, 1);
        repeat (3) step_g(0, r1(), r1(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0), "run_low");

        step_g(1, 1, r1(), ev(0, 1, 1, 0, 0, 0, 0, 0, 0), "fetch");
        step(r1(), r1(), r1(), 1, 0, 0, 0, r1(), 1, ev(1, 0, 0, 0, 0, 0, 0, 0, 0), "decode_ill");
        m_cause = 1;
        halt_steps(4);

        do_reset(0, "reset_after_halt");
        do_instr(K_LOAD, 0, TMO, 0);
        halt_steps(3);
        do_reset(0, "reset_dmem_to");
        do_instr(K_ALU, TMO, 0, 0);
        halt_steps(3);
        do_reset(0, "reset_imem_to");
        do_instr(K_ALU, 0, 0, 0);
        do_instr(K_LOAD, 1, -1, 0);
        do_reset(1, "reset_mid_mem");
        do_instr(K_STORE, 0, 1, 0);

        do_reset(0, "reset_wrap");
        repeat (15) do_instr(K_ALU, 0, 0, 0);
        step_g(0, r1(), r1(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0), "idle");
        chk("wrap_pre", 32'(o_instret), 32'd15);
        do_instr(K_BR, 0, 0, 1);
        step_g(0, r1(), r1(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0), "idle");
        chk("wrap_zero", 32'(o_instret), 32'd0);

        repeat (60) begin
            repeat ($urandom_range(2, 0))
                step_g(0, r1(), r1(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0), "idle");
            do_instr(int'($urandom_range(4, 0)), int'($urandom_range(3, 0)),
                     int'($urandom_range(3, 0)), r1());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
